rom_stream_reader: RTL

- Initiator-side controller for the synchronous ROM (10-bit address, 8-bit data, one-cycle read latency).
- On a start command it reads a contiguous range of ROM words and presents them, one at a time, on a valid/ready output stream.
- Sits between the ROM and the FSM datapath blocks that consume table data.

---
 rtl/rom_stream_reader.sv | 71 +++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads a contiguous ROM range and streams it out over valid/ready
module rom_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, SEND} state_t;
    state_t state;
    logic [ADDR_W:0] remaining;
    // control FSM: issue address, capture ROM word, hold it on the stream until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            out_data  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (length != '0) begin
                        rom_addr  <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                ISSUE: state <= CAPT;
                CAPT: begin
                    out_data  <= rom_data;
                    out_valid <= 1'b1;
                    out_last  <= (remaining == (ADDR_W+1)'(1));
                    state     <= SEND;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    remaining <= remaining - 1'b1;
                    if (out_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
